// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 8-bit RISC-V pipeline.
// Computes the ALU result, beq decision and branch target, and registers them
// together with the forwarded control bits into the EX/MEM pipeline register.
// Optional build macro FORWARD_EN adds MEM/WB operand forwarding ports.
module ex_stage #(
  parameter int unsigned PC_SIZE = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_SIZE-1:0] pc_in,
  input  logic               reg_write_in,
  input  logic               branch_in,
  input  logic               mem_read_in,
  input  logic               mem_to_reg_in,
  input  logic               mem_write_in,
  input  logic [1:0]         alu_op,
  input  logic               alu_src,
  input  logic [7:0]         read_data1,
  input  logic [7:0]         read_data2,
  input  logic [11:0]        immediate,
  input  logic [9:0]         funct,
  input  logic [4:0]         rd_in,
`ifdef FORWARD_EN
  input  logic               fwd_mem_en,
  input  logic [4:0]         fwd_mem_rd,
  input  logic [7:0]         fwd_mem_data,
  input  logic               fwd_wb_en,
  input  logic [4:0]         fwd_wb_rd,
  input  logic [7:0]         fwd_wb_data,
  input  logic [4:0]         rs1_in,
  input  logic [4:0]         rs2_in,
`endif
  output logic [7:0]         alu_result,
  output logic               zero,
  output logic               branch_taken,
  output logic [PC_SIZE-1:0] branch_target,
  output logic [7:0]         store_data,
  output logic               reg_write_out,
  output logic               mem_read_out,
  output logic               mem_to_reg_out,
  output logic               mem_write_out,
  output logic [4:0]         rd_out
);

  logic [7:0]         op_a;
  logic [7:0]         rs2_val;
  logic [7:0]         op_b;
  logic [2:0]         shamt;
  logic [7:0]         alu_next;
  logic               zero_next;
  logic [PC_SIZE-1:0] target_next;

`ifdef FORWARD_EN
  // Operand selection with MEM-stage forwarding taking priority over WB; x0 never forwards
  always_comb begin
    op_a    = read_data1;
    rs2_val = read_data2;
    if (fwd_mem_en && (fwd_mem_rd == rs1_in) && (rs1_in != 5'd0))
      op_a = fwd_mem_data;
    else if (fwd_wb_en && (fwd_wb_rd == rs1_in) && (rs1_in != 5'd0))
      op_a = fwd_wb_data;
    if (fwd_mem_en && (fwd_mem_rd == rs2_in) && (rs2_in != 5'd0))
      rs2_val = fwd_mem_data;
    else if (fwd_wb_en && (fwd_wb_rd == rs2_in) && (rs2_in != 5'd0))
      rs2_val = fwd_wb_data;
  end
`else
  // Operands come straight from the register file read ports
  always_comb begin
    op_a    = read_data1;
    rs2_val = read_data2;
  end
`endif

  assign op_b  = alu_src ? immediate[7:0] : rs2_val;
  assign shamt = op_b[2:0];

  // ALU operation decode: fixed add/sub, full R-type decode, or funct3-only I-type decode
  always_comb begin
    alu_next = '0;
    case (alu_op)
      2'b00: alu_next = op_a + op_b;
      2'b01: alu_next = op_a - op_b;
      2'b10: begin
        case (funct)
          10'b0000000_000: alu_next = op_a + op_b;
          10'b0100000_000: alu_next = op_a - op_b;
          10'b0000000_111: alu_next = op_a & op_b;
          10'b0000000_110: alu_next = op_a | op_b;
          10'b0000000_100: alu_next = op_a ^ op_b;
          10'b0000000_001: alu_next = op_a << shamt;
          10'b0000000_101: alu_next = op_a >> shamt;
          default:         alu_next = '0;
        endcase
      end
      default: begin
        case (funct[2:0])
          3'b000:  alu_next = op_a + op_b;
          3'b111:  alu_next = op_a & op_b;
          3'b110:  alu_next = op_a | op_b;
          3'b100:  alu_next = op_a ^ op_b;
          3'b001:  alu_next = op_a << shamt;
          3'b101:  alu_next = op_a >> shamt;
          default: alu_next = '0;
        endcase
      end
    endcase
  end

  assign zero_next   = (alu_next == '0);
  assign target_next = pc_in + PC_SIZE'($signed({immediate, 1'b0}));

  // EX/MEM register: reset beats stall, stall beats flush, flush only clears control bits
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_result     <= '0;
      zero           <= 1'b0;
      branch_taken   <= 1'b0;
      branch_target  <= '0;
      store_data     <= '0;
      reg_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_to_reg_out <= 1'b0;
      mem_write_out  <= 1'b0;
      rd_out         <= '0;
    end else if (!stall) begin
      alu_result     <= alu_next;
      zero           <= zero_next;
      branch_taken   <= branch_in & zero_next & ~flush;
      branch_target  <= target_next;
      store_data     <= rs2_val;
      reg_write_out  <= reg_write_in & ~flush;
      mem_read_out   <= mem_read_in & ~flush;
      mem_to_reg_out <= mem_to_reg_in & ~flush;
      mem_write_out  <= mem_write_in & ~flush;
      rd_out         <= rd_in;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;

  localparam int unsigned PC_SIZE = 10;

  logic               clock = 1'b0;
  logic               reset, stall, flush;
  logic [PC_SIZE-1:0] pc_in;
  logic               reg_write_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in;
  logic [1:0]         alu_op;
  logic               alu_src;
  logic [7:0]         read_data1, read_data2;
  logic [11:0]        immediate;
  logic [9:0]         funct;
  logic [4:0]         rd_in;
`ifdef FORWARD_EN
  logic               fwd_mem_en, fwd_wb_en;
  logic [4:0]         fwd_mem_rd, fwd_wb_rd, rs1_in, rs2_in;
  logic [7:0]         fwd_mem_data, fwd_wb_data;
`endif
  logic [7:0]         alu_result, store_data;
  logic               zero, branch_taken;
  logic [PC_SIZE-1:0] branch_target;
  logic               reg_write_out, mem_read_out, mem_to_reg_out, mem_write_out;
  logic [4:0]         rd_out;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state (expected EX/MEM contents)
  int e_alu, e_zero, e_bt, e_tgt, e_store, e_rw, e_mr, e_m2r, e_mw, e_rd;

  ex_stage #(.PC_SIZE(PC_SIZE)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .pc_in(pc_in),
    .reg_write_in(reg_write_in), .branch_in(branch_in), .mem_read_in(mem_read_in),
    .mem_to_reg_in(mem_to_reg_in), .mem_write_in(mem_write_in), .alu_op(alu_op),
    .alu_src(alu_src), .read_data1(read_data1), .read_data2(read_data2),
    .immediate(immediate), .funct(funct), .rd_in(rd_in),
`ifdef FORWARD_EN
    .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .rs1_in(rs1_in), .rs2_in(rs2_in),
`endif
    .alu_result(alu_result), .zero(zero), .branch_taken(branch_taken),
    .branch_target(branch_target), .store_data(store_data),
    .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_to_reg_out(mem_to_reg_out), .mem_write_out(mem_write_out), .rd_out(rd_out)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  // Value of an ALU operation computed with plain integer arithmetic
  function automatic int ref_alu(int op, int f, int a, int b);
    int f7 = f / 8;
    int f3 = f % 8;
    int p  = 1 << (b % 8);
    int r  = 0;
    if (op == 0) r = a + b;
    else if (op == 1) r = a - b + 256;
    else if (op == 2) begin
      if (f7 == 32 && f3 == 0) r = a - b + 256;
      else if (f7 == 0) begin
        if (f3 == 0) r = a + b;
        else if (f3 == 7) r = a & b;
        else if (f3 == 6) r = a | b;
        else if (f3 == 4) r = a ^ b;
        else if (f3 == 1) r = a * p;
        else if (f3 == 5) r = a / p;
      end
    end else begin
      if (f3 == 0) r = a + b;
      else if (f3 == 7) r = a & b;
      else if (f3 == 6) r = a | b;
      else if (f3 == 4) r = a ^ b;
      else if (f3 == 1) r = a * p;
      else if (f3 == 5) r = a / p;
    end
    return r % 256;
  endfunction

  function automatic logic [36:0] got_vec();
    return {alu_result, zero, branch_taken, branch_target, store_data,
            reg_write_out, mem_read_out, mem_to_reg_out, mem_write_out, rd_out};
  endfunction

  function automatic logic [36:0] exp_vec();
    return {8'(e_alu), 1'(e_zero), 1'(e_bt), 10'(e_tgt), 8'(e_store),
            1'(e_rw), 1'(e_mr), 1'(e_m2r), 1'(e_mw), 5'(e_rd)};
  endfunction

  // One clock edge: model absorbs the inputs present at the edge; outputs sampled 1 time unit later
  task automatic step();
    int a, s, b, r;
    @(posedge clock);
    a = int'(read_data1);
    s = int'(read_data2);
`ifdef FORWARD_EN
    if (fwd_mem_en && fwd_mem_rd == rs1_in && rs1_in != 0) a = int'(fwd_mem_data);
    else if (fwd_wb_en && fwd_wb_rd == rs1_in && rs1_in != 0) a = int'(fwd_wb_data);
    if (fwd_mem_en && fwd_mem_rd == rs2_in && rs2_in != 0) s = int'(fwd_mem_data);
    else if (fwd_wb_en && fwd_wb_rd == rs2_in && rs2_in != 0) s = int'(fwd_wb_data);
`endif
    b = alu_src ? (int'(immediate) % 256) : s;
    r = ref_alu(int'(alu_op), int'(funct), a, b);
    if (reset) begin
      e_alu = 0; e_zero = 0; e_bt = 0; e_tgt = 0; e_store = 0;
      e_rw = 0; e_mr = 0; e_m2r = 0; e_mw = 0; e_rd = 0;
    end else if (!stall) begin
      e_alu   = r;
      e_zero  = (r == 0) ? 1 : 0;
      e_bt    = (branch_in && r == 0 && !flush) ? 1 : 0;
      e_tgt   = (int'(pc_in) + 2 * int'(immediate)) % (1 << PC_SIZE);
      e_store = s;
      e_rw    = (reg_write_in && !flush) ? 1 : 0;
      e_mr    = (mem_read_in && !flush) ? 1 : 0;
      e_m2r   = (mem_to_reg_in && !flush) ? 1 : 0;
      e_mw    = (mem_write_in && !flush) ? 1 : 0;
      e_rd    = int'(rd_in);
    end
    #1;
  endtask

  task automatic randomize_inputs();
    pc_in         = PC_SIZE'($urandom);
    reg_write_in  = 1'($urandom);
    branch_in     = 1'($urandom);
    mem_read_in   = 1'($urandom);
    mem_to_reg_in = 1'($urandom);
    mem_write_in  = 1'($urandom);
    alu_op        = 2'($urandom);
    alu_src       = 1'($urandom);
    read_data1    = 8'($urandom);
    read_data2    = ($urandom_range(0, 3) == 0) ? read_data1 : 8'($urandom);
    immediate     = 12'($urandom);
    case ($urandom_range(0, 8))
      0: funct = 10'b0000000_000;
      1: funct = 10'b0100000_000;
      2: funct = 10'b0000000_111;
      3: funct = 10'b0000000_110;
      4: funct = 10'b0000000_100;
      5: funct = 10'b0000000_001;
      6: funct = 10'b0000000_101;
      default: funct = 10'($urandom);
    endcase
    rd_in = 5'($urandom);
`ifdef FORWARD_EN
    fwd_mem_en   = 1'($urandom);
    fwd_wb_en    = 1'($urandom);
    fwd_mem_rd   = 5'($urandom_range(0, 3));
    fwd_wb_rd    = 5'($urandom_range(0, 3));
    rs1_in       = 5'($urandom_range(0, 3));
    rs2_in       = 5'($urandom_range(0, 3));
    fwd_mem_data = 8'($urandom);
    fwd_wb_data  = 8'($urandom);
`endif
  endtask

  task automatic clear_ctrl();
    reg_write_in = 0; branch_in = 0; mem_read_in = 0; mem_to_reg_in = 0; mem_write_in = 0;
    alu_src = 0; funct = '0; immediate = '0; pc_in = '0; rd_in = '0;
`ifdef FORWARD_EN
    fwd_mem_en = 0; fwd_wb_en = 0; fwd_mem_rd = '0; fwd_wb_rd = '0;
    rs1_in = '0; rs2_in = '0; fwd_mem_data = '0; fwd_wb_data = '0;
`endif
  endtask

  task automatic test_reset();
    stall = 0; flush = 0; reset = 1;
    randomize_inputs();
    reg_write_in = 1; read_data1 = 8'h5A; alu_op = 2'b00;
    step();
    step();
    n_cmp++;
    if (got_vec() !== 37'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", got_vec());
    end
    reset = 0;
  endtask

  task automatic test_sub_rtype();
    clear_ctrl();
    alu_op = 2'b10; funct = 10'b0100000_000; read_data1 = 8'h05; read_data2 = 8'h07;
    step();
    n_cmp++;
    if (alu_result !== 8'hFE || zero !== 1'b0) begin
      n_err++;
      $display("FAIL rtype_sub: got alu=%h zero=%b expected alu=fe zero=0", alu_result, zero);
    end
  endtask

  task automatic test_branch_wrap();
    clear_ctrl();
    alu_op = 2'b01; branch_in = 1; read_data1 = 8'h3C; read_data2 = 8'h3C;
    pc_in = 10'h3F0; immediate = 12'h010;
    step();
    n_cmp++;
    if (branch_taken !== 1'b1 || zero !== 1'b1 || branch_target !== 10'h010) begin
      n_err++;
      $display("FAIL branch_wrap: got taken=%b zero=%b target=%h expected 1 1 010",
               branch_taken, zero, branch_target);
    end
    read_data2 = 8'h3D;
    step();
    n_cmp++;
    if (branch_taken !== 1'b0 || zero !== 1'b0) begin
      n_err++;
      $display("FAIL branch_not_taken: got taken=%b zero=%b expected 0 0", branch_taken, zero);
    end
  endtask

  task automatic test_slli();
    clear_ctrl();
    alu_op = 2'b11; funct = 10'b1111111_001; alu_src = 1; immediate = 12'h00B;
    read_data1 = 8'h81; read_data2 = 8'hFF;
    step();
    n_cmp++;
    if (alu_result !== 8'h08) begin
      n_err++;
      $display("FAIL itype_slli: got %h expected 08", alu_result);
    end
  endtask

  task automatic test_stall_flush();
    clear_ctrl();
    alu_op = 2'b00; read_data1 = 8'h10; read_data2 = 8'h20; rd_in = 5'd9; reg_write_in = 1;
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      flush = 1'($urandom);
      step();
      n_cmp++;
      if (alu_result !== 8'h30 || rd_out !== 5'd9 || reg_write_out !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold: got alu=%h rd=%0d rw=%b expected 30 9 1",
                 alu_result, rd_out, reg_write_out);
      end
    end
    stall = 0; flush = 1;
    clear_ctrl();
    alu_op = 2'b00; read_data1 = 8'h03; read_data2 = 8'h04;
    reg_write_in = 1; mem_write_in = 1; rd_in = 5'd7;
    step();
    n_cmp++;
    if (reg_write_out !== 1'b0 || mem_write_out !== 1'b0 || alu_result !== 8'h07 || rd_out !== 5'd7) begin
      n_err++;
      $display("FAIL flush: got rw=%b mw=%b alu=%h rd=%0d expected 0 0 07 7",
               reg_write_out, mem_write_out, alu_result, rd_out);
    end
    flush = 0;
    stall = 1; reset = 1;
    step();
    n_cmp++;
    if (got_vec() !== 37'd0) begin
      n_err++;
      $display("FAIL reset_during_stall: got %h expected 0", got_vec());
    end
    stall = 0; reset = 0;
  endtask

`ifdef FORWARD_EN
  task automatic test_forward();
    clear_ctrl();
    alu_op = 2'b00; rs1_in = 5'd3; rs2_in = 5'd5;
    read_data1 = 8'h77; read_data2 = 8'h01;
    fwd_mem_en = 1; fwd_mem_rd = 5'd3; fwd_mem_data = 8'h11;
    fwd_wb_en = 1;  fwd_wb_rd = 5'd3;  fwd_wb_data = 8'h22;
    step();
    n_cmp++;
    if (alu_result !== 8'h12) begin
      n_err++;
      $display("FAIL fwd_mem_priority: got %h expected 12", alu_result);
    end
    rs1_in = 5'd0; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0; read_data1 = 8'h40;
    step();
    n_cmp++;
    if (alu_result !== 8'h41) begin
      n_err++;
      $display("FAIL fwd_x0_ignored: got %h expected 41", alu_result);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      reset = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      step();
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random_%0d: got %h expected %h", i, got_vec(), exp_vec());
      end
    end
    reset = 0; stall = 0; flush = 0;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    clear_ctrl();
    alu_op = '0; read_data1 = '0; read_data2 = '0;
    test_reset();
    test_sub_rtype();
    test_branch_wrap();
    test_slli();
    test_stall_flush();
`ifdef FORWARD_EN
    test_forward();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 8-bit RISC-V pipeline. It consumes the ID/EX pipeline register fields driven by the decode stage and computes the ALU result, branch decision and branch target. The results are captured into the EX/MEM pipeline register. The stage also carries the destination register tag and write-enable forward so that writeback can return write_reg_data, write_register and reg_write to decode.

Parameters:
PC_SIZE, 10, width of program counter / branch target

Ports:
clock  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
stall  input  1  hold all EX/MEM registers this cycle
flush  input  1  squash the instruction entering EX/MEM (control bits forced 0)
pc_in  input  PC_SIZE  PC of instruction in EX
reg_write_in  input  1  ID/EX register-write enable
branch_in  input  1  ID/EX branch flag
mem_read_in  input  1  ID/EX load flag
mem_to_reg_in  input  1  ID/EX writeback select
mem_write_in  input  1  ID/EX store flag
alu_op  input  2  00 add, 01 sub, 10 R-type, 11 I-type
alu_src  input  1  1 selects immediate as operand B
read_data1  input  8  rs1 value
read_data2  input  8  rs2 value
immediate  input  12  sign-extended-later immediate
funct  input  10  {funct7, funct3}
rd_in  input  5  destination register
alu_result  output  8  registered ALU result
zero  output  1  registered (alu_result == 0)
branch_taken  output  1  registered branch & zero
branch_target  output  PC_SIZE  registered pc_in + (immediate << 1)
store_data  output  8  registered read_data2
reg_write_out, mem_read_out, mem_to_reg_out, mem_write_out  output  1 each  registered control
rd_out  output  5  registered destination register

Behaviour:
- Reset (synchronous, priority over stall/flush): all outputs 0.
- Latency: 1 cycle from ID/EX inputs to EX/MEM outputs.
- Operand B = alu_src ? immediate[7:0] : read_data2.
- alu_op 00: A+B. 01: A-B. 10: funct 0000000_000 add, 0100000_000 sub, 0000000_111 and, 0000000_110 or, 0000000_100 xor, 0000000_001 sll, 0000000_101 srl, others yield 0. 11: funct3 only (000 addi, 111 andi, 110 ori, 100 xori, 001 slli, 101 srli, others 0).
- All arithmetic is modulo 2^8. Shift amount = B[2:0].
- zero = (8-bit result == 0). branch_taken = branch_in & zero (beq semantics).
- branch_target = pc_in + {immediate, 1'b0}, truncated to PC_SIZE bits; wrap-around is silent.
- stall=1: every output register holds its value; stall has priority over flush.
- flush=1 (stall=0): reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out and branch_taken are captured as 0; data fields capture normally.
- reset asserted mid-stall clears all outputs on that edge.

Optional Feature:
FORWARD_EN: when defined, adds inputs fwd_mem_en(1), fwd_mem_rd(5), fwd_mem_data(8), fwd_wb_en(1), fwd_wb_rd(5), fwd_wb_data(8), plus rs1_in(5) and rs2_in(5).
- Forwarding selects operand A and rs2 data: an MEM match (fwd_mem_en, rd == rs, rd != 0) has priority over a WB match.
- Operand B takes forwarded rs2 only when alu_src=0; store_data always uses forwarded rs2.
- When FORWARD_EN is undefined, these ports are absent and operands come directly from read_data1/read_data2.

Test Plan:
- reset=1 for 2 cycles with nonzero inputs -> all outputs 0.
- alu_op=10, funct=0100000_000, rs1=0x05, rs2=0x07 -> alu_result=0xFE, zero=0 next cycle.
- alu_op=01, branch_in=1, rs1=rs2=0x3C, pc_in=0x3F0, immediate=0x010 -> branch_taken=1, branch_target=0x010 (wrap-around).
- alu_op=11, funct3=001, alu_src=1, immediate=0x00B, rs1=0x81 -> alu_result=0x08 (shift 3).
- stall=1 while inputs change -> outputs unchanged. Then flush=1 with reg_write_in=1, mem_write_in=1 -> those outputs 0, alu_result updated.
- FORWARD_EN: MEM and WB both match rs1=x3 (MEM data 0x11, WB data 0x22), rs2 data 0x01, add -> alu_result=0x12. With rd=x0 in both -> no forwarding.
